// File: rtl/bus_scheduler.sv
// Time-division scheduler for the shared CPU/RAM/IO bus: each CPU cycle is split into
// a video slot, an MCU slot and a 6502 slot, with PHI2, bus enable and CPU reset generated here.
module bus_scheduler #(
    parameter int CYCLE_COUNT  = 64,
    parameter int VIDEO_CYCLES = 12,
    parameter int WB_CYCLES    = 12,
    parameter int PHI1_CYCLES  = 32,
    parameter int RESET_CYCLES = 8
) (
    input  logic                           sys_clock_i,
    input  logic                           sys_reset_ni,
    input  logic                           cpu_run_i,
    input  logic                           cpu_reset_req_i,
    input  logic                           wb_req_i,
    output logic                           wb_grant_o,
    output logic                           wb_strobe_o,
    output logic                           wb_ack_o,
    output logic                           video_grant_o,
    output logic                           video_strobe_o,
    output logic                           cpu_be_o,
    output logic                           cpu_clock_o,
    output logic                           cpu_strobe_o,
    output logic                           cpu_reset_o,
    output logic [$clog2(CYCLE_COUNT)-1:0] cycle_o
);
    localparam int CW = $clog2(CYCLE_COUNT);
    localparam int RW = ($clog2(RESET_CYCLES + 1) < 3) ? 3 : $clog2(RESET_CYCLES + 1);

    localparam logic [CW-1:0] LP_WB_FIRST   = CW'(VIDEO_CYCLES);
    localparam logic [CW-1:0] LP_CPU_FIRST  = CW'(VIDEO_CYCLES + WB_CYCLES);
    localparam logic [CW-1:0] LP_PHI2_FIRST = CW'(PHI1_CYCLES);
    localparam logic [CW-1:0] LP_LAST       = CW'(CYCLE_COUNT - 1);
    localparam logic [RW-1:0] LP_RST_LOAD   = RW'(RESET_CYCLES);

    logic          r_started;
    logic [CW-1:0] r_cycle;
    logic          r_run;
    logic [RW-1:0] r_rstCnt;

    logic [CW-1:0] w_next;
    logic          w_frameStart;
    logic          w_wbGrant;
    logic          w_wbStrobe;
    logic          w_wbAck;
    logic          w_rstDec;
    logic [RW-1:0] w_rstCnt;
    logic          w_cpuReset;

    assign cycle_o = r_cycle;

    // Outputs are registered from the count they will accompany; the first clock after
    // reset release holds the count at 0 so the first frame begins cleanly at cycle 0.
    always_comb begin
        w_next       = r_started ? (r_cycle + CW'(1)) : '0;
        w_frameStart = (w_next == '0);

        w_wbGrant = 1'b0;
        if (w_next == LP_WB_FIRST) begin
            w_wbGrant = wb_req_i;
        end else if ((w_next > LP_WB_FIRST) && (w_next < LP_CPU_FIRST)) begin
            w_wbGrant = wb_grant_o;
        end else if (!r_run && (w_next == LP_CPU_FIRST)) begin
            // A request still high from a first-slot ack must not be granted twice.
            w_wbGrant = wb_req_i && !wb_grant_o;
        end else if (!r_run && (w_next > LP_CPU_FIRST)) begin
            w_wbGrant = wb_grant_o;
        end
        w_wbStrobe = w_wbGrant && ((w_next == LP_WB_FIRST) || (w_next == LP_CPU_FIRST));
        w_wbAck    = w_wbGrant && ((w_next == LP_CPU_FIRST - CW'(1)) || (w_next == LP_LAST));

        w_rstDec = r_started && w_frameStart && (r_rstCnt != '0);
        w_rstCnt = r_rstCnt;
        if (cpu_reset_req_i) begin
            w_rstCnt = LP_RST_LOAD;
        end else if (w_rstDec) begin
            w_rstCnt = r_rstCnt - RW'(1);
        end

        w_cpuReset = cpu_reset_o;
        if (cpu_reset_req_i) begin
            w_cpuReset = 1'b1;
        end else if (w_frameStart && (w_rstCnt == '0)) begin
            w_cpuReset = 1'b0;
        end
    end

    // The run flag is latched only at a frame boundary so the 6502 never sees a partial cycle.
    always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
        if (!sys_reset_ni) begin
            r_started      <= 1'b0;
            r_cycle        <= '0;
            r_run          <= 1'b0;
            r_rstCnt       <= LP_RST_LOAD;
            wb_grant_o     <= 1'b0;
            wb_strobe_o    <= 1'b0;
            wb_ack_o       <= 1'b0;
            video_grant_o  <= 1'b0;
            video_strobe_o <= 1'b0;
            cpu_be_o       <= 1'b0;
            cpu_clock_o    <= 1'b0;
            cpu_strobe_o   <= 1'b0;
            cpu_reset_o    <= 1'b1;
        end else begin
            r_started      <= 1'b1;
            r_cycle        <= w_next;
            if (w_frameStart) begin
                r_run <= cpu_run_i;
            end
            r_rstCnt       <= w_rstCnt;
            wb_grant_o     <= w_wbGrant;
            wb_strobe_o    <= w_wbStrobe;
            wb_ack_o       <= w_wbAck;
            video_grant_o  <= (w_next < LP_WB_FIRST);
            video_strobe_o <= w_frameStart;
            cpu_be_o       <= r_run && (w_next >= LP_CPU_FIRST);
            cpu_clock_o    <= r_run && (w_next >= LP_PHI2_FIRST);
            cpu_strobe_o   <= r_run && (w_next == LP_LAST);
            cpu_reset_o    <= w_cpuReset;
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed self-checking bench for bus_scheduler: walks whole frames and compares every
// output each cycle against hand-derived slot timing.
module tb_bus_scheduler;

    logic       sys_clock_i;
    logic       sys_reset_ni;
    logic       cpu_run_i;
    logic       cpu_reset_req_i;
    logic       wb_req_i;
    logic       wb_grant_o;
    logic       wb_strobe_o;
    logic       wb_ack_o;
    logic       video_grant_o;
    logic       video_strobe_o;
    logic       cpu_be_o;
    logic       cpu_clock_o;
    logic       cpu_strobe_o;
    logic       cpu_reset_o;
    logic [5:0] cycle_o;

    int checks = 0;
    int errors = 0;

    logic [8:0] obs;
    assign obs = {wb_grant_o, wb_strobe_o, wb_ack_o, video_grant_o, video_strobe_o,
                  cpu_be_o, cpu_clock_o, cpu_strobe_o, cpu_reset_o};

    bus_scheduler dut (
        .sys_clock_i     (sys_clock_i),
        .sys_reset_ni    (sys_reset_ni),
        .cpu_run_i       (cpu_run_i),
        .cpu_reset_req_i (cpu_reset_req_i),
        .wb_req_i        (wb_req_i),
        .wb_grant_o      (wb_grant_o),
        .wb_strobe_o     (wb_strobe_o),
        .wb_ack_o        (wb_ack_o),
        .video_grant_o   (video_grant_o),
        .video_strobe_o  (video_strobe_o),
        .cpu_be_o        (cpu_be_o),
        .cpu_clock_o     (cpu_clock_o),
        .cpu_strobe_o    (cpu_strobe_o),
        .cpu_reset_o     (cpu_reset_o),
        .cycle_o         (cycle_o)
    );

    initial sys_clock_i = 1'b0;
    always #5 sys_clock_i = ~sys_clock_i;

    // Expected outputs for cycle n: 12-cycle video slot, MCU slot 12..23, CPU slot 24..63,
    // PHI2 high 32..63; a paused frame turns 24..63 into a second MCU slot.
    function automatic logic [8:0] expVec(int n, bit run, bit wb1, bit wb2, bit rst);
        logic wbG, wbS, wbA;
        wbG = (wb1 && n >= 12 && n <= 23) || (!run && wb2 && n >= 24);
        wbS = (wb1 && n == 12) || (!run && wb2 && n == 24);
        wbA = (wb1 && n == 23) || (!run && wb2 && n == 63);
        return {wbG, wbS, wbA, 1'(n < 12), 1'(n == 0),
                1'(run && n >= 24), 1'(run && n >= 32), 1'(run && n == 63), rst};
    endfunction

    task automatic waitCycle(input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge sys_clock_i);
            if (cycle_o == 6'(n)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitCycle timeout got cycle %0d expected %0d", cycle_o, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clock_i);
        checks++;
        if (obs !== 9'b000000001) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected %b", obs, 9'b000000001);
        end
        checks++;
        if (cycle_o !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_cycle got %0d expected 0", cycle_o);
        end
        sys_reset_ni = 1'b1;
    endtask

    task automatic test_cpu_frames();
        logic [14:0] exp;
        for (int f = 0; f < 10; f++) begin
            for (int n = 0; n < 64; n++) begin
                @(negedge sys_clock_i);
                exp = {6'(n), expVec(n, 1'b1, 1'b0, 1'b0, f < 8)};
                checks++;
                if ({cycle_o, obs} !== exp) begin
                    errors++;
                    $display("[TB] FAIL cpu_frames f=%0d n=%0d got %h expected %h", f, n, {cycle_o, obs}, exp);
                end
            end
        end
    endtask

    task automatic test_wb_grant();
        logic [14:0] exp;
        waitCycle(5);
        wb_req_i = 1'b1;
        for (int n = 5; n < 64; n++) begin
            if (n != 5) @(negedge sys_clock_i);
            exp = {6'(n), expVec(n, 1'b1, 1'b1, 1'b0, 1'b0)};
            checks++;
            if ({cycle_o, obs} !== exp) begin
                errors++;
                $display("[TB] FAIL wb_grant n=%0d got %h expected %h", n, {cycle_o, obs}, exp);
            end
            if (n == 24) wb_req_i = 1'b0;
        end
    endtask

    task automatic test_late_req();
        logic [14:0] exp;
        int f, n;
        waitCycle(15);
        wb_req_i = 1'b1;
        for (int k = 15; k < 128; k++) begin
            f = k / 64;
            n = k % 64;
            if (k != 15) @(negedge sys_clock_i);
            exp = {6'(n), expVec(n, 1'b1, f == 1, 1'b0, 1'b0)};
            checks++;
            if ({cycle_o, obs} !== exp) begin
                errors++;
                $display("[TB] FAIL late_req f=%0d n=%0d got %h expected %h", f, n, {cycle_o, obs}, exp);
            end
            if (f == 1 && n == 24) wb_req_i = 1'b0;
        end
    endtask

    task automatic test_pause();
        logic [14:0] exp;
        int f, n;
        waitCycle(40);
        cpu_run_i = 1'b0;
        for (int k = 40; k < 192; k++) begin
            f = k / 64;
            n = k % 64;
            if (k != 40) @(negedge sys_clock_i);
            case (f)
                0:       exp = {6'(n), expVec(n, 1'b1, 1'b0, 1'b0, 1'b0)};
                1:       exp = {6'(n), expVec(n, 1'b0, 1'b0, 1'b1, 1'b0)};
                default: exp = {6'(n), expVec(n, 1'b0, 1'b1, 1'b0, 1'b0)};
            endcase
            checks++;
            if ({cycle_o, obs} !== exp) begin
                errors++;
                $display("[TB] FAIL pause f=%0d n=%0d got %h expected %h", f, n, {cycle_o, obs}, exp);
            end
            if (f == 1 && n == 20) wb_req_i = 1'b1;
            if (f == 2 && n == 0)  wb_req_i = 1'b0;
            if (f == 2 && n == 5)  wb_req_i = 1'b1;
            if (f == 2 && n == 24) wb_req_i = 1'b0;
            if (f == 2 && n == 40) cpu_run_i = 1'b1;
        end
    endtask

    task automatic test_cpu_reset();
        logic [14:0] exp;
        int f, n;
        bit rst;
        waitCycle(50);
        for (int k = 50; k < 11 * 64 + 4; k++) begin
            f = k / 64;
            n = k % 64;
            if (k != 50) @(negedge sys_clock_i);
            rst = (f == 0) ? (n > 50) : (f <= 10);
            exp = {6'(n), expVec(n, 1'b1, 1'b0, 1'b0, rst)};
            checks++;
            if ({cycle_o, obs} !== exp) begin
                errors++;
                $display("[TB] FAIL cpu_reset f=%0d n=%0d got %h expected %h", f, n, {cycle_o, obs}, exp);
            end
            if (k == 50 || k == 3 * 64 + 50) cpu_reset_req_i = 1'b1;
            if (k == 51 || k == 3 * 64 + 51) cpu_reset_req_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [14:0] exp;
        waitCycle(40);
        cpu_run_i = 1'b0;
        waitCycle(20);
        wb_req_i = 1'b1;
        waitCycle(30);
        checks++;
        if (obs !== expVec(30, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL mid_grant_pre got %b expected %b", obs, expVec(30, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        sys_reset_ni = 1'b0;
        #1;
        checks++;
        if ({cycle_o, obs} !== {6'd0, 9'b000000001}) begin
            errors++;
            $display("[TB] FAIL mid_grant_async got %h expected %h", {cycle_o, obs}, {6'd0, 9'b000000001});
        end
        wb_req_i  = 1'b0;
        cpu_run_i = 1'b1;
        repeat (2) @(negedge sys_clock_i);
        sys_reset_ni = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge sys_clock_i);
            exp = {6'(n), expVec(n, 1'b1, 1'b0, 1'b0, 1'b1)};
            checks++;
            if ({cycle_o, obs} !== exp) begin
                errors++;
                $display("[TB] FAIL mid_grant_restart n=%0d got %h expected %h", n, {cycle_o, obs}, exp);
            end
        end
    endtask

    initial begin
        sys_reset_ni    = 1'b0;
        cpu_run_i       = 1'b1;
        cpu_reset_req_i = 1'b0;
        wb_req_i        = 1'b0;
        test_reset();
        test_cpu_frames();
        test_wb_grant();
        test_late_req();
        test_pause();
        test_cpu_reset();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
